// File: rtl/ex_muldiv_if.sv
// Handshake and result bundle between the EX stage and the iterative multiply/divide unit.
// The pipeline side is the master; the arithmetic unit is the slave.
interface ex_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic             flush;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, srcA, srcB, flush,
        input  stall, busy, done, hi, lo
    );

    modport slave (
        input  start, op, srcA, srcB, flush,
        output stall, busy, done, hi, lo
    );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative 32-cycle multiply/divide unit for the EX stage.
// Works on operand magnitudes and applies sign correction on the final iteration.
module ex_muldiv #(
    parameter int WIDTH = 32
) (
    input logic        clk,
    input logic        rst,
    ex_muldiv_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} stateT;

    stateT              state;
    stateT              nextState;
    logic [4:0]         cnt;
    logic               isDiv;
    logic               negLow;
    logic               negHigh;
    logic [WIDTH-1:0]   operand;
    logic [WIDTH-1:0]   hiReg;
    logic [WIDTH-1:0]   loReg;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] stepAcc;
    logic [2*WIDTH-1:0] finalAcc;
    logic [WIDTH:0]     addSum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH-1:0]   remSub;
    logic [WIDTH-1:0]   magA;
    logic [WIDTH-1:0]   magB;
    logic               signA;
    logic               signB;
    logic               stallInt;
    logic               busyInt;
    logic               doneInt;
    logic               accept;
    logic               finish;

    assign signA  = ~bus.op[0] & bus.srcA[WIDTH-1];
    assign signB  = ~bus.op[0] & bus.srcB[WIDTH-1];
    assign magA   = signA ? -bus.srcA : bus.srcA;
    assign magB   = signB ? -bus.srcB : bus.srcB;
    assign accept = (state == IDLE) && bus.start && !bus.flush;
    assign finish = (state == CALC) && !bus.flush && (cnt == 5'd31);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        stallInt  = 1'b0;
        busyInt   = 1'b0;
        doneInt   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    nextState = CALC;
                    stallInt  = 1'b1;
                end
            end
            CALC: begin
                stallInt = 1'b1;
                busyInt  = 1'b1;
                if (bus.flush) begin
                    nextState = IDLE;
                end else if (cnt == 5'd31) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                busyInt   = 1'b1;
                doneInt   = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Multiply keeps {partial product, remaining multiplier bits} in acc;
    // divide keeps {partial remainder, dividend bits becoming quotient bits}.
    always_comb begin
        addSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        remSub  = shifted[WIDTH-1:0] - operand;
        if (!isDiv) begin
            stepAcc = {addSum, acc[WIDTH-1:1]};
        end else if (shifted >= {1'b0, operand}) begin
            stepAcc = {remSub, acc[WIDTH-2:0], 1'b1};
        end else begin
            stepAcc = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
        if (!isDiv) begin
            finalAcc = negLow ? -stepAcc : stepAcc;
        end else begin
            finalAcc = {negHigh ? -stepAcc[2*WIDTH-1:WIDTH] : stepAcc[2*WIDTH-1:WIDTH],
                        negLow  ? -stepAcc[WIDTH-1:0]       : stepAcc[WIDTH-1:0]};
        end
    end

    // A zero divisor leaves the quotient at all ones, so its sign is never corrected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= 5'd0;
            isDiv   <= 1'b0;
            negLow  <= 1'b0;
            negHigh <= 1'b0;
            operand <= '0;
            acc     <= '0;
            hiReg   <= '0;
            loReg   <= '0;
        end else if (accept) begin
            cnt     <= 5'd0;
            isDiv   <= bus.op[1];
            negLow  <= bus.op[1] ? ((signA ^ signB) & (|bus.srcB)) : (signA ^ signB);
            negHigh <= bus.op[1] & signA;
            operand <= bus.op[1] ? magB : magA;
            acc     <= {{WIDTH{1'b0}}, (bus.op[1] ? magA : magB)};
        end else if (state == CALC) begin
            cnt <= cnt + 5'd1;
            acc <= stepAcc;
            if (finish) begin
                hiReg <= finalAcc[2*WIDTH-1:WIDTH];
                loReg <= finalAcc[WIDTH-1:0];
            end
        end
    end

    assign bus.stall = stallInt & ~rst;
    assign bus.busy  = busyInt;
    assign bus.done  = doneInt;
    assign bus.hi    = hiReg;
    assign bus.lo    = loReg;
endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: directed literal cases plus randomized operations
// compared every cycle against a plain-arithmetic reference model.
module tb_ex_muldiv;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    bit   cmpEnable = 1'b0;

    ex_muldiv_if #(.WIDTH(32)) bus();

    ex_muldiv #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference result {hi, lo} straight from the arithmetic definition of each op.
    function automatic logic [63:0] refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [31:0] qa;
        logic signed [31:0] qb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        qa = a;
        qb = b;
        case (op)
            2'b00: return sa * sb;
            2'b01: return {32'd0, a} * {32'd0, b};
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
                return {32'(qa % qb), 32'(qa / qb)};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Cycle-level model: an accepted op finishes 32 edges later unless flushed.
    bit          mActive;
    bit          mDoneCycle;
    int          mAge;
    logic [1:0]  mOp;
    logic [31:0] mA;
    logic [31:0] mB;
    logic [31:0] mHi;
    logic [31:0] mLo;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mActive    = 1'b0;
            mDoneCycle = 1'b0;
            mAge       = 0;
            mHi        = 32'd0;
            mLo        = 32'd0;
        end else if (mDoneCycle) begin
            mDoneCycle = 1'b0;
        end else if (mActive) begin
            if (bus.flush) begin
                mActive = 1'b0;
            end else begin
                mAge++;
                if (mAge == 32) begin
                    {mHi, mLo} = refModel(mOp, mA, mB);
                    mActive    = 1'b0;
                    mDoneCycle = 1'b1;
                end
            end
        end else if (bus.start && !bus.flush) begin
            mActive = 1'b1;
            mAge    = 0;
            mOp     = bus.op;
            mA      = bus.srcA;
            mB      = bus.srcB;
        end
    end

    always @(negedge clk) begin
        if (cmpEnable && !rst) begin
            checkOutput("busy",  {63'd0, bus.busy},  {63'd0, (mActive || mDoneCycle)});
            checkOutput("done",  {63'd0, bus.done},  {63'd0, mDoneCycle});
            checkOutput("stall", {63'd0, bus.stall},
                        {63'd0, (mActive || (!mDoneCycle && bus.start && !bus.flush))});
            checkOutput("hi", {32'd0, bus.hi}, {32'd0, mHi});
            checkOutput("lo", {32'd0, bus.lo}, {32'd0, mLo});
        end
    end

    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input bit scramble, output int stallCycles, output bit gotDone);
        @(posedge clk);
        #1;
        bus.op    = o;
        bus.srcA  = a;
        bus.srcB  = b;
        bus.flush = 1'b0;
        bus.start = 1'b1;
        stallCycles = 0;
        gotDone     = 1'b0;
        for (int i = 0; i < 40 && !gotDone; i++) begin
            @(negedge clk);
            if (bus.stall) stallCycles++;
            if (bus.done) begin
                gotDone = 1'b1;
            end else if (scramble && bus.busy) begin
                #1;
                bus.op   = 2'($urandom_range(0, 3));
                bus.srcA = $urandom;
                bus.srcB = $urandom;
            end
        end
        #1;
        bus.start = 1'b0;
        if (!gotDone) checkOutput("doneTimeout", 64'd0, 64'd1);
    endtask

    task automatic runDirected(input string name, input logic [1:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expHi, input logic [31:0] expLo);
        int stallCycles;
        bit gotDone;
        applyStimulus(o, a, b, 1'b0, stallCycles, gotDone);
        checkOutput({name, "_hi"}, {32'd0, bus.hi}, {32'd0, expHi});
        checkOutput({name, "_lo"}, {32'd0, bus.lo}, {32'd0, expLo});
        checkOutput({name, "_stallCycles"}, 64'(stallCycles), 64'd33);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int stallCycles;
        bit gotDone;
        int donePulses;
        logic [1:0]  rOp;
        logic [31:0] rB;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.srcA  = 32'd0;
        bus.srcB  = 32'd0;
        bus.flush = 1'b0;
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        #1;
        checkOutput("rst_hi",    {32'd0, bus.hi}, 64'd0);
        checkOutput("rst_lo",    {32'd0, bus.lo}, 64'd0);
        checkOutput("rst_busy",  {63'd0, bus.busy}, 64'd0);
        checkOutput("rst_done",  {63'd0, bus.done}, 64'd0);
        checkOutput("rst_stall", {63'd0, bus.stall}, 64'd0);
        bus.start = 1'b0;
        #1;
        rst = 1'b0;
        cmpEnable = 1'b1;

        runDirected("multNeg",   2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
        runDirected("multuMax",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        runDirected("divNeg",    2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        runDirected("divu100_7", 2'b11, 32'd100,      32'd7,        32'd2,        32'd14);
        runDirected("divuZero",  2'b11, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF);
        runDirected("divOvf",    2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000);
        runDirected("preload",   2'b01, 32'd2,        32'h80000001, 32'd1,        32'd2);

        // Flush an in-flight MULTU during its tenth CALC cycle.
        @(posedge clk);
        #1;
        bus.op    = 2'b01;
        bus.srcA  = 32'd5;
        bus.srcB  = 32'd5;
        bus.start = 1'b1;
        @(negedge clk);
        repeat (10) @(negedge clk);
        #1;
        bus.flush = 1'b1;
        @(negedge clk);
        checkOutput("flush_busy",  {63'd0, bus.busy}, 64'd0);
        checkOutput("flush_stall", {63'd0, bus.stall}, 64'd0);
        checkOutput("flush_hi",    {32'd0, bus.hi}, 64'd1);
        checkOutput("flush_lo",    {32'd0, bus.lo}, 64'd2);
        #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        donePulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) donePulses++;
        end
        checkOutput("flush_donePulses", 64'(donePulses), 64'd0);

        // Reset between edges in the middle of a divide.
        @(posedge clk);
        #1;
        bus.op    = 2'b11;
        bus.srcA  = 32'd1000;
        bus.srcB  = 32'd3;
        bus.start = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midRst_hi",    {32'd0, bus.hi}, 64'd0);
        checkOutput("midRst_lo",    {32'd0, bus.lo}, 64'd0);
        checkOutput("midRst_busy",  {63'd0, bus.busy}, 64'd0);
        checkOutput("midRst_done",  {63'd0, bus.done}, 64'd0);
        checkOutput("midRst_stall", {63'd0, bus.stall}, 64'd0);
        #1;
        rst = 1'b0;
        bus.start = 1'b0;
        runDirected("divu9_3", 2'b11, 32'd9, 32'd3, 32'd0, 32'd3);

        // Randomized ops with operands scrambled while the unit is computing.
        for (int n = 0; n < 24; n++) begin
            rOp = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0:       rB = 32'd0;
                1:       rB = 32'($urandom_range(1, 15));
                2:       rB = 32'hFFFFFFFF;
                default: rB = $urandom;
            endcase
            applyStimulus(rOp, $urandom, rB, 1'b1, stallCycles, gotDone);
            checkOutput("rand_stallCycles", 64'(stallCycles), 64'd33);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
